// File: rtl/ccd_timing_gen.sv
// TCD1304-class linear CCD timing generator: master clock M, ICG/SH gates,
// electronic shutter pulses and per-pixel ADC strobes, all from one clock.
module ccd_timing_gen #(
  parameter int CLK_DIV    = 25,
  parameter int FRAME_CLKS = 1000000,
  parameter int ICG_START  = 5,
  parameter int ICG_WIDTH  = 375,
  parameter int SH_DELAY   = 30,
  parameter int SH_WIDTH   = 100,
  parameter int DUMMY_LEAD = 32,
  parameter int ACTIVE_PIX = 3648,
  parameter int SAMPLE_OFS = 100,
  parameter int CNT_W      = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             single,
  input  logic [CNT_W-1:0] int_period,
  output logic             M,
  output logic             ICG,
  output logic             SH,
  output logic             frame_start,
  output logic             pix_valid,
  output logic [11:0]      pix_idx,
  output logic             line_done,
  output logic             busy
);

  localparam int PIX_CLKS = 8 * CLK_DIV;
  localparam int P0       = ICG_START + ICG_WIDTH + SAMPLE_OFS + DUMMY_LEAD * PIX_CLKS;
  localparam int E_LAST   = P0 + (ACTIVE_PIX - 1) * PIX_CLKS;
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PC_W     = $clog2(PIX_CLKS + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] F_LAST   = CNT_W'(FRAME_CLKS - 1);
  localparam logic [CNT_W-1:0] F_CLKS   = CNT_W'(FRAME_CLKS);
  localparam logic [CNT_W-1:0] ICG_FALL = CNT_W'(ICG_START);
  localparam logic [CNT_W-1:0] ICG_RISE = CNT_W'(ICG_START + ICG_WIDTH);
  localparam logic [CNT_W-1:0] SH_AT    = CNT_W'(SH_DELAY);
  localparam logic [CNT_W-1:0] SH_HOLD  = CNT_W'(SH_WIDTH - 1);
  localparam logic [CNT_W-1:0] LS_MIN   = CNT_W'(2 * SH_WIDTH);
  localparam logic [CNT_W-1:0] SH_LATE  = CNT_W'(FRAME_CLKS - SH_WIDTH - 1);
  localparam logic [CNT_W-1:0] P0_AT    = CNT_W'(P0);
  localparam logic [CNT_W-1:0] DONE_AT  = CNT_W'(E_LAST + 1);
  localparam logic [PC_W-1:0]  PIX_PER  = PC_W'(PIX_CLKS);
  localparam logic [11:0]      IDX_PEN  = 12'(ACTIVE_PIX - 2);

  if (FRAME_CLKS % (2 * CLK_DIV) != 0) begin : g_chk_div
    $error("FRAME_CLKS must be a multiple of 2*CLK_DIV");
  end
  if (ICG_START >= SH_DELAY) begin : g_chk_sh_start
    $error("ICG_START must be less than SH_DELAY");
  end
  if (SH_DELAY + SH_WIDTH >= ICG_START + ICG_WIDTH) begin : g_chk_sh_end
    $error("transfer SH pulse must end inside ICG low");
  end
  if (FRAME_CLKS <= E_LAST + 1) begin : g_chk_frame
    $error("FRAME_CLKS too short for the pixel readout");
  end

  typedef enum logic [1:0] {IDLE, RUN, LAST} state_t;

  state_t           state;
  logic [CNT_W-1:0] fcnt;
  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] sh_cnt;
  logic [CNT_W-1:0] scnt;
  logic [CNT_W-1:0] ls;
  logic             shut_en;
  logic             single_l;
  logic             pix_on;
  logic [PC_W-1:0]  pcnt;

  // A latched period of 0 means the shutter is disabled for the frame.
  function automatic logic [CNT_W-1:0] calc_ls(input logic [CNT_W-1:0] p);
    if (p == '0 || p >= F_CLKS) return '0;
    if (p < LS_MIN) return LS_MIN;
    return p;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      fcnt        <= '0;
      div_cnt     <= '0;
      sh_cnt      <= '0;
      scnt        <= '0;
      ls          <= '0;
      shut_en     <= 1'b0;
      single_l    <= 1'b0;
      pix_on      <= 1'b0;
      pcnt        <= '0;
      M           <= 1'b0;
      ICG         <= 1'b1;
      SH          <= 1'b0;
      frame_start <= 1'b0;
      pix_valid   <= 1'b0;
      pix_idx     <= '0;
      line_done   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        M       <= ~M;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      frame_start <= 1'b0;
      pix_valid   <= 1'b0;
      line_done   <= 1'b0;

      if (state == IDLE) begin
        fcnt    <= '0;
        ICG     <= 1'b1;
        SH      <= 1'b0;
        shut_en <= 1'b0;
        pix_on  <= 1'b0;
        // Restarting the divider here locks M phase to fcnt for every run.
        if (start) begin
          state       <= stop ? LAST : RUN;
          busy        <= 1'b1;
          frame_start <= 1'b1;
          ls          <= calc_ls(int_period);
          single_l    <= single;
          div_cnt     <= '0;
          M           <= 1'b0;
        end
      end else begin
        if (fcnt == ICG_FALL) ICG <= 1'b0;
        if (fcnt == ICG_RISE) ICG <= 1'b1;

        if (SH) begin
          if (sh_cnt == '0) SH <= 1'b0;
          else sh_cnt <= sh_cnt - CNT_W'(1);
        end

        // Shutter pulses late enough to overrun the frame end are dropped.
        if (fcnt == SH_AT) begin
          SH      <= 1'b1;
          sh_cnt  <= SH_HOLD;
          scnt    <= CNT_W'(1);
          shut_en <= (ls != '0);
        end else if (shut_en) begin
          if (scnt == ls) begin
            if (fcnt >= SH_LATE) begin
              shut_en <= 1'b0;
            end else begin
              SH     <= 1'b1;
              sh_cnt <= SH_HOLD;
              scnt   <= CNT_W'(1);
            end
          end else begin
            scnt <= scnt + CNT_W'(1);
          end
        end

        if (fcnt == P0_AT) begin
          pix_valid <= 1'b1;
          pix_idx   <= '0;
          pcnt      <= PC_W'(1);
          pix_on    <= (ACTIVE_PIX > 1);
        end else if (pix_on) begin
          if (pcnt == PIX_PER) begin
            pix_valid <= 1'b1;
            pix_idx   <= pix_idx + 12'd1;
            pcnt      <= PC_W'(1);
            if (pix_idx == IDX_PEN) pix_on <= 1'b0;
          end else begin
            pcnt <= pcnt + PC_W'(1);
          end
        end

        if (fcnt == DONE_AT) line_done <= 1'b1;

        if (fcnt == F_LAST) begin
          fcnt    <= '0;
          shut_en <= 1'b0;
          if (state == LAST || single_l || stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            frame_start <= 1'b1;
            ls          <= calc_ls(int_period);
            single_l    <= single;
          end
        end else begin
          fcnt <= fcnt + CNT_W'(1);
          if (stop) state <= LAST;
        end
      end
    end
  end

endmodule

// File: tb/tb_ccd_timing_gen.sv
// Directed bench for ccd_timing_gen using the small test-plan configuration
// (frame 2000 clocks, P0=117, E_last=1125).
module tb_ccd_timing_gen;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        single;
  logic [19:0] int_period;
  logic        M, ICG, SH, frame_start, pix_valid, line_done, busy;
  logic [11:0] pix_idx;

  int n_checks = 0;
  int n_fail   = 0;

  logic        m_a    [0:4099];
  logic        icg_a  [0:4099];
  logic        sh_a   [0:4099];
  logic        fs_a   [0:4099];
  logic        pv_a   [0:4099];
  logic        ld_a   [0:4099];
  logic        busy_a [0:4099];
  logic [11:0] idx_a  [0:4099];

  ccd_timing_gen #(
    .CLK_DIV(2), .FRAME_CLKS(2000), .ICG_START(5), .ICG_WIDTH(40),
    .SH_DELAY(10), .SH_WIDTH(20), .DUMMY_LEAD(4), .ACTIVE_PIX(64),
    .SAMPLE_OFS(8), .CNT_W(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .single(single),
    .int_period(int_period), .M(M), .ICG(ICG), .SH(SH),
    .frame_start(frame_start), .pix_valid(pix_valid), .pix_idx(pix_idx),
    .line_done(line_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic exp_icg(input int f);
    return !(f >= 6 && f <= 45);
  endfunction

  function automatic logic exp_sh(input int f, input int ls);
    if (f >= 11 && f <= 30) return 1'b1;
    if (ls > 0)
      for (int x = 10 + ls; x <= 1978; x += ls)
        if (f >= x + 1 && f <= x + 20) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic exp_pv(input int f);
    return (f >= 118 && f <= 1126 && ((f - 118) % 16) == 0);
  endfunction

  task automatic begin_frame(input logic with_stop);
    start = 1'b1;
    stop  = with_stop;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic capture(input int n, input int start_at, input int stop_at,
                         input int ip_at, input logic [19:0] ip_val);
    for (int c = 0; c < n; c++) begin
      m_a[c] = M;   icg_a[c] = ICG;  sh_a[c] = SH;   fs_a[c] = frame_start;
      pv_a[c] = pix_valid; ld_a[c] = line_done; busy_a[c] = busy; idx_a[c] = pix_idx;
      start = (c == start_at);
      stop  = (c == stop_at);
      if (c == ip_at) int_period = ip_val;
      @(negedge clk);
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic hard_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; single = 1'b0; int_period = '0;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (M !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("[TB] FAIL reset_m_static: %0d cycles with M!=0, required 0", bad); end
    n_checks++;
    if ({ICG, SH, frame_start, pix_valid, line_done, busy} !== 6'b100000) begin
      n_fail++; $display("[TB] FAIL reset_gates: got %b required 100000", {ICG, SH, frame_start, pix_valid, line_done, busy});
    end
    n_checks++;
    if (pix_idx !== 12'd0) begin n_fail++; $display("[TB] FAIL reset_pix_idx: got %0d required 0", pix_idx); end
    rst_n = 1'b1;
    bad = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (M !== 1'((k >> 1) & 1)) bad++;
      if (ICG !== 1'b1 || busy !== 1'b0) bad += 100;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("[TB] FAIL reset_release: bad score %0d, required 0", bad); end
  endtask

  task automatic test_continuous();
    int b_fs, b_icg, b_sh, b_m, b_busy, f;
    int_period = '0; single = 1'b0;
    b_fs = 0; b_icg = 0; b_sh = 0; b_m = 0; b_busy = 0;
    begin_frame(1'b0);
    capture(4000, 1500, -1, -1, 20'd0);
    for (int c = 0; c < 4000; c++) begin
      f = c % 2000;
      if (fs_a[c] !== (f == 0)) b_fs++;
      if (icg_a[c] !== exp_icg(f)) b_icg++;
      if (sh_a[c] !== exp_sh(f, 0)) b_sh++;
      if (m_a[c] !== 1'((f >> 1) & 1)) b_m++;
      if (busy_a[c] !== 1'b1) b_busy++;
    end
    n_checks++;
    if (b_fs !== 0) begin n_fail++; $display("[TB] FAIL cont_frame_start: %0d bad cycles, required 0", b_fs); end
    n_checks++;
    if (b_icg !== 0) begin n_fail++; $display("[TB] FAIL cont_icg: %0d bad cycles, required 0", b_icg); end
    n_checks++;
    if (b_sh !== 0) begin n_fail++; $display("[TB] FAIL cont_sh: %0d bad cycles, required 0", b_sh); end
    n_checks++;
    if (b_m !== 0) begin n_fail++; $display("[TB] FAIL cont_m_phase: %0d bad cycles, required 0", b_m); end
    n_checks++;
    if (b_busy !== 0) begin n_fail++; $display("[TB] FAIL cont_busy: %0d bad cycles, required 0", b_busy); end
    hard_reset();
  endtask

  task automatic test_shutter();
    int b_sh, rises;
    int ips  [2] = '{500, 30};
    int lss  [2] = '{500, 40};
    int nr   [2] = '{4, 50};
    single = 1'b0;
    for (int t = 0; t < 2; t++) begin
      int_period = 20'(ips[t]);
      b_sh = 0; rises = 0;
      begin_frame(1'b0);
      capture(2000, -1, -1, -1, 20'd0);
      for (int c = 0; c < 2000; c++) begin
        if (sh_a[c] !== exp_sh(c, lss[t])) b_sh++;
        if (c > 0 && sh_a[c] === 1'b1 && sh_a[c-1] === 1'b0) rises++;
      end
      n_checks++;
      if (b_sh !== 0) begin n_fail++; $display("[TB] FAIL shutter_pattern_%0d: %0d bad cycles, required 0", ips[t], b_sh); end
      n_checks++;
      if (rises !== nr[t]) begin n_fail++; $display("[TB] FAIL shutter_rises_%0d: got %0d required %0d", ips[t], rises, nr[t]); end
      hard_reset();
    end
  endtask

  task automatic test_pixels();
    int b_pv, b_idx, b_ld, n_pv, n_ld;
    int_period = '0; single = 1'b0;
    b_pv = 0; b_idx = 0; b_ld = 0; n_pv = 0; n_ld = 0;
    begin_frame(1'b0);
    capture(2000, -1, -1, -1, 20'd0);
    for (int c = 0; c < 2000; c++) begin
      if (pv_a[c] !== exp_pv(c)) b_pv++;
      if (exp_pv(c) && idx_a[c] !== 12'((c - 118) / 16)) b_idx++;
      if (ld_a[c] !== (c == 1127)) b_ld++;
      if (pv_a[c] === 1'b1) n_pv++;
      if (ld_a[c] === 1'b1) n_ld++;
    end
    n_checks++;
    if (b_pv !== 0) begin n_fail++; $display("[TB] FAIL pix_valid_timing: %0d bad cycles, required 0", b_pv); end
    n_checks++;
    if (b_idx !== 0) begin n_fail++; $display("[TB] FAIL pix_idx_values: %0d bad strobes, required 0", b_idx); end
    n_checks++;
    if (n_pv !== 64) begin n_fail++; $display("[TB] FAIL pix_count: got %0d required 64", n_pv); end
    n_checks++;
    if (b_ld !== 0 || n_ld !== 1) begin n_fail++; $display("[TB] FAIL line_done: %0d bad cycles, %0d pulses, required 0 and 1", b_ld, n_ld); end
    hard_reset();
  endtask

  task automatic one_frame_then_idle(input string name, input logic with_stop,
                                     input int stop_at);
    int b_busy, b_fs, b_icg, n_ld;
    b_busy = 0; b_fs = 0; b_icg = 0; n_ld = 0;
    begin_frame(with_stop);
    capture(2010, -1, stop_at, -1, 20'd0);
    for (int c = 0; c < 2010; c++) begin
      if (busy_a[c] !== (c < 2000)) b_busy++;
      if (fs_a[c] !== (c == 0)) b_fs++;
      if (icg_a[c] !== (c < 2000 ? exp_icg(c) : 1'b1)) b_icg++;
      if (ld_a[c] === 1'b1) n_ld++;
    end
    n_checks++;
    if (b_busy !== 0) begin n_fail++; $display("[TB] FAIL %s_busy: %0d bad cycles, required 0", name, b_busy); end
    n_checks++;
    if (b_fs !== 0) begin n_fail++; $display("[TB] FAIL %s_frame_start: %0d bad cycles, required 0", name, b_fs); end
    n_checks++;
    if (b_icg !== 0 || n_ld !== 1) begin
      n_fail++; $display("[TB] FAIL %s_frame_body: %0d bad ICG cycles, %0d line_done, required 0 and 1", name, b_icg, n_ld);
    end
  endtask

  task automatic test_single();
    int_period = '0; single = 1'b1;
    one_frame_then_idle("single", 1'b0, -1);
    single = 1'b0;
  endtask

  task automatic test_stop();
    int_period = '0; single = 1'b0;
    one_frame_then_idle("stop", 1'b0, 700);
  endtask

  task automatic test_back_to_back();
    int_period = '0; single = 1'b0;
    one_frame_then_idle("start_stop", 1'b1, -1);
  endtask

  task automatic test_config_change();
    int b1, b2;
    int_period = 20'd300; single = 1'b0;
    b1 = 0; b2 = 0;
    begin_frame(1'b0);
    capture(4000, -1, -1, 1000, 20'd600);
    for (int c = 0; c < 2000; c++)
      if (sh_a[c] !== exp_sh(c, 300)) b1++;
    for (int c = 2000; c < 4000; c++)
      if (sh_a[c] !== exp_sh(c - 2000, 600)) b2++;
    n_checks++;
    if (b1 !== 0) begin n_fail++; $display("[TB] FAIL cfg_frame1_sh300: %0d bad cycles, required 0", b1); end
    n_checks++;
    if (b2 !== 0) begin n_fail++; $display("[TB] FAIL cfg_frame2_sh600: %0d bad cycles, required 0", b2); end
    hard_reset();
  endtask

  task automatic test_mid_reset();
    int bad;
    int_period = '0; single = 1'b0;
    begin_frame(1'b0);
    capture(20, -1, -1, -1, 20'd0);
    n_checks++;
    if (ICG !== 1'b0 || SH !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_before: ICG=%b SH=%b required 0 1", ICG, SH); end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({ICG, SH, busy, pix_valid, frame_start} !== 5'b10000) begin
      n_fail++; $display("[TB] FAIL midrst_after: got %b required 10000", {ICG, SH, busy, pix_valid, frame_start});
    end
    rst_n = 1'b1;
    capture(50, -1, -1, -1, 20'd0);
    bad = 0;
    for (int c = 0; c < 50; c++)
      if (busy_a[c] !== 1'b0 || icg_a[c] !== 1'b1 || sh_a[c] !== 1'b0 || fs_a[c] !== 1'b0) bad++;
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("[TB] FAIL midrst_idle: %0d bad cycles, required 0", bad); end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_shutter();
    test_pixels();
    test_single();
    test_stop();
    test_config_change();
    test_mid_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
